// File: rtl/loop_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : loop_div_pkg
// Purpose  : Shared constants, state encoding and ratio legality check for the
//            PLL feedback-divider ratio controller.
// Revision : 1.0 - initial release
// ============================================================================
package loop_div_pkg;

    localparam int DIV_W = 6;

    localparam logic [1:0] c_st_run    = 2'd0;
    localparam logic [1:0] c_st_pend   = 2'd1;
    localparam logic [1:0] c_st_settle = 2'd2;

    // Fractional mode needs headroom for N+1, so its ceiling is one lower.
    function automatic logic ratio_legal(
        input logic [DIV_W-1:0] n_int,
        input logic             mode,
        input int               n_min,
        input int               n_max
    );
        int v;
        v = int'(n_int);
        return (v >= n_min) && (v <= n_max - int'(mode));
    endfunction

endpackage
`default_nettype wire

// File: rtl/loop_div_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : loop_div_ctrl_if
// Purpose  : Ratio-request handshake bundle (requester = master, ctrl = slave).
// Revision : 1.0 - initial release
// ============================================================================
interface loop_div_ctrl_if
    import loop_div_pkg::*;
#(
    parameter int FRAC_W = 8
);
    logic              cfg_valid;
    logic              cfg_ready;
    logic [DIV_W-1:0]  cfg_n_int;
    logic [FRAC_W-1:0] cfg_frac;
    logic              cfg_mode;

    modport master (
        output cfg_valid, cfg_n_int, cfg_frac, cfg_mode,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid, cfg_n_int, cfg_frac, cfg_mode,
        output cfg_ready
    );
endinterface
`default_nettype wire

// File: rtl/loop_div_frac_acc.sv
`default_nettype none
// ============================================================================
// Module   : loop_div_frac_acc
// Purpose  : First-order fractional accumulator; carry selects N+1 for a period.
// Revision : 1.0 - initial release
// ============================================================================
module loop_div_frac_acc #(
    parameter int FRAC_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rstn_s,
    input  wire logic              i_clr,
    input  wire logic              i_en,
    input  wire logic [FRAC_W-1:0] i_frac,
    output logic                   o_carry
);
    logic [FRAC_W-1:0] r_acc;
    logic [FRAC_W:0]   w_sum;

    // Carry is the overflow of the step about to be taken, so it is valid in
    // the same cycle as the enable that consumes it.
    assign w_sum   = {1'b0, r_acc} + {1'b0, i_frac};
    assign o_carry = w_sum[FRAC_W];

    always_ff @(posedge clk or negedge rstn_s) begin
        if (!rstn_s) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_sum[FRAC_W-1:0];
        end
    end
endmodule
`default_nettype wire

// File: rtl/loop_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : loop_div_ctrl
// Purpose  : PLL feedback-divider ratio controller; applies ratios only at
//            divider period boundaries, with optional fractional dithering.
// Revision : 1.0 - initial release
// ============================================================================
module loop_div_ctrl
    import loop_div_pkg::*;
#(
    parameter int FRAC_W = 8,
    parameter int N_MIN  = 2,
    parameter int N_MAX  = 63,
    parameter int N_RST  = 8,
    parameter int SETTLE = 4,
    parameter int WDOG   = 255
) (
    input  wire logic             clk,
    input  wire logic             rstn_s,
    loop_div_ctrl_if.slave        cfg,
    input  wire logic             div_wrap,
    output logic [DIV_W-1:0]      div_n,
    output logic                  busy,
    output logic                  cfg_err,
    output logic                  wdog_to
);
    localparam int c_wdog_w = $clog2(WDOG + 1);
    localparam int c_set_w  = $clog2(SETTLE + 1);

    logic [1:0]          r_state;
    logic                r_cfg_ready;
    logic                r_busy;
    logic [DIV_W-1:0]    r_div_n;
    logic [DIV_W-1:0]    r_n_int;
    logic [FRAC_W-1:0]   r_frac;
    logic                r_mode;
    logic                r_cfg_err;
    logic                r_wdog_to;
    logic [c_wdog_w-1:0] r_wdog_cnt;
    logic [c_set_w-1:0]  r_settle_cnt;

    logic       w_hs;
    logic       w_legal;
    logic       w_wdog_lim;
    logic       w_pend_fire;
    logic       w_settle_done;
    logic       w_acc_en;
    logic       w_carry;
    logic [1:0] w_state_nxt;

    always_comb begin
        w_hs          = cfg.cfg_valid && r_cfg_ready;
        w_legal       = ratio_legal(cfg.cfg_n_int, cfg.cfg_mode, N_MIN, N_MAX);
        w_wdog_lim    = (r_wdog_cnt == c_wdog_w'(WDOG));
        w_pend_fire   = (r_state == c_st_pend) && (div_wrap || w_wdog_lim);
        w_settle_done = (r_state == c_st_settle) && div_wrap &&
                        (r_settle_cnt == c_set_w'(SETTLE - 1));
        w_acc_en      = (r_state == c_st_run) && r_mode && div_wrap;
        w_state_nxt   = r_state;
        case (r_state)
            c_st_run:    if (w_hs && w_legal) w_state_nxt = c_st_pend;
            c_st_pend:   if (w_pend_fire)     w_state_nxt = c_st_settle;
            c_st_settle: if (w_settle_done)   w_state_nxt = c_st_run;
            default:                          w_state_nxt = c_st_run;
        endcase
    end

    loop_div_frac_acc #(
        .FRAC_W (FRAC_W)
    ) u_frac_acc (
        .clk     (clk),
        .rstn_s  (rstn_s),
        .i_clr   (w_pend_fire),
        .i_en    (w_acc_en),
        .i_frac  (r_frac),
        .o_carry (w_carry)
    );

    always_ff @(posedge clk or negedge rstn_s) begin
        if (!rstn_s) begin
            r_state      <= c_st_run;
            r_cfg_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_div_n      <= DIV_W'(N_RST);
            r_n_int      <= DIV_W'(N_RST);
            r_frac       <= '0;
            r_mode       <= 1'b0;
            r_cfg_err    <= 1'b0;
            r_wdog_to    <= 1'b0;
            r_wdog_cnt   <= '0;
            r_settle_cnt <= '0;
        end else begin
            // Handshake flags are registered from the next state so no
            // output depends combinationally on an input.
            r_state     <= w_state_nxt;
            r_cfg_ready <= (w_state_nxt == c_st_run);
            r_busy      <= (w_state_nxt != c_st_run);
            case (r_state)
                c_st_run: begin
                    if (w_acc_en) begin
                        r_div_n <= r_n_int + DIV_W'(w_carry);
                    end
                    if (w_hs) begin
                        if (w_legal) begin
                            r_n_int    <= cfg.cfg_n_int;
                            r_frac     <= cfg.cfg_frac;
                            r_mode     <= cfg.cfg_mode;
                            r_cfg_err  <= 1'b0;
                            r_wdog_to  <= 1'b0;
                            r_wdog_cnt <= '0;
                        end else begin
                            r_cfg_err  <= 1'b1;
                        end
                    end
                end
                c_st_pend: begin
                    if (w_pend_fire) begin
                        r_div_n      <= r_n_int;
                        r_settle_cnt <= '0;
                        // A real wrap at the limit wins over the watchdog.
                        if (!div_wrap) begin
                            r_wdog_to <= 1'b1;
                        end
                    end else begin
                        r_wdog_cnt <= r_wdog_cnt + c_wdog_w'(1);
                    end
                end
                c_st_settle: begin
                    if (div_wrap && !w_settle_done) begin
                        r_settle_cnt <= r_settle_cnt + c_set_w'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign cfg.cfg_ready = r_cfg_ready;
    assign div_n         = r_div_n;
    assign busy          = r_busy;
    assign cfg_err       = r_cfg_err;
    assign wdog_to       = r_wdog_to;
endmodule
`default_nettype wire

// File: tb/tb_loop_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_loop_div_ctrl
// Purpose  : Self-checking bench for loop_div_ctrl against a ratio-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_loop_div_ctrl;
    localparam int FRAC_W = 8;

    logic       clk      = 1'b0;
    logic       rstn_s   = 1'b0;
    logic       div_wrap = 1'b0;
    logic [5:0] div_n;
    logic       busy;
    logic       cfg_err;
    logic       wdog_to;

    int n_checks = 0;
    int n_errors = 0;

    // Model: current ratio, fraction, mode, dither periods since settle, last div_n.
    int mdl_n    = 8;
    int mdl_frac = 0;
    int mdl_mode = 0;
    int mdl_k    = 0;
    int mdl_last = 8;

    loop_div_ctrl_if #(.FRAC_W(FRAC_W)) cfg ();

    loop_div_ctrl #(
        .FRAC_W (FRAC_W),
        .N_MIN  (2),
        .N_MAX  (63),
        .N_RST  (8),
        .SETTLE (4),
        .WDOG   (255)
    ) dut (
        .clk      (clk),
        .rstn_s   (rstn_s),
        .cfg      (cfg),
        .div_wrap (div_wrap),
        .div_n    (div_n),
        .busy     (busy),
        .cfg_err  (cfg_err),
        .wdog_to  (wdog_to)
    );

    always #5 clk = ~clk;

    // Mean ratio n + f/256: period k gets the increment of floor((k+1)f/256).
    function automatic int dither_n(input int k);
        if (mdl_mode == 0) return mdl_n;
        return mdl_n + ((k + 1) * mdl_frac) / 256 - (k * mdl_frac) / 256;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrap_after(input int gap);
        div_wrap = 1'b0;
        repeat (gap - 1) tick();
        div_wrap = 1'b1;
        tick();
        div_wrap = 1'b0;
    endtask

    task automatic drive_req(input int n, input int f, input bit m, input bit with_wrap);
        cfg.cfg_valid = 1'b1;
        cfg.cfg_n_int = 6'(n);
        cfg.cfg_frac  = 8'(f);
        cfg.cfg_mode  = m;
        div_wrap      = with_wrap;
        tick();
        cfg.cfg_valid = 1'b0;
        div_wrap      = 1'b0;
        cfg.cfg_n_int = 6'($urandom);
        cfg.cfg_frac  = 8'($urandom);
        cfg.cfg_mode  = 1'($urandom);
    endtask

    task automatic test_reset();
        cfg.cfg_valid = 1'b0;
        cfg.cfg_n_int = '0;
        cfg.cfg_frac  = '0;
        cfg.cfg_mode  = 1'b0;
        rstn_s = 1'b0;
        #12;
        n_checks++; if (div_n !== 6'd8) begin n_errors++; $display("FAIL reset_div_n: got %0d expected 8", div_n); end
        n_checks++; if (busy !== 1'b0 || cfg.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL reset_flags: busy %b ready %b expected 0 1", busy, cfg.cfg_ready); end
        n_checks++; if (cfg_err !== 1'b0 || wdog_to !== 1'b0) begin n_errors++; $display("FAIL reset_sticky: err %b wdog %b expected 0 0", cfg_err, wdog_to); end
        @(negedge clk);
        rstn_s = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wrap_after(8);
            n_checks++; if (div_n !== 6'd8 || busy !== 1'b0 || cfg.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL idle_run: div_n %0d busy %b ready %b expected 8 0 1", div_n, busy, cfg.cfg_ready); end
        end
    endtask

    task automatic test_integer_change();
        drive_req(12, 0, 1'b0, 1'b0);
        n_checks++; if (busy !== 1'b1 || cfg.cfg_ready !== 1'b0) begin n_errors++; $display("FAIL int_busy: busy %b ready %b expected 1 0", busy, cfg.cfg_ready); end
        repeat (5) tick();
        n_checks++; if (div_n !== 6'd8) begin n_errors++; $display("FAIL int_hold_pend: got %0d expected 8", div_n); end
        div_wrap = 1'b1;
        tick();
        div_wrap = 1'b0;
        n_checks++; if (div_n !== 6'd12) begin n_errors++; $display("FAIL int_apply: got %0d expected 12", div_n); end
        for (int i = 1; i <= 4; i++) begin
            wrap_after(8);
            n_checks++; if (busy !== (i < 4) || div_n !== 6'd12) begin n_errors++; $display("FAIL int_settle: wrap %0d busy %b div_n %0d expected %b 12", i, busy, div_n, (i < 4)); end
        end
        mdl_n = 12; mdl_frac = 0; mdl_mode = 0; mdl_k = 0; mdl_last = 12;
    endtask

    task automatic test_illegal();
        drive_req(1, 0, 1'b0, 1'b0);
        n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || div_n !== 6'(mdl_last)) begin n_errors++; $display("FAIL illegal_low: err %b busy %b div_n %0d expected 1 0 %0d", cfg_err, busy, div_n, mdl_last); end
        wrap_after(3);
        n_checks++; if (div_n !== 6'(mdl_last) || busy !== 1'b0) begin n_errors++; $display("FAIL illegal_noeffect: div_n %0d busy %b expected %0d 0", div_n, busy, mdl_last); end
        drive_req(63, 16, 1'b1, 1'b0);
        n_checks++; if (cfg_err !== 1'b1 || busy !== 1'b0 || cfg.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL illegal_frac63: err %b busy %b ready %b expected 1 0 1", cfg_err, busy, cfg.cfg_ready); end
        drive_req(10, 0, 1'b0, 1'b0);
        n_checks++; if (cfg_err !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL illegal_clear: err %b busy %b expected 0 1", cfg_err, busy); end
        wrap_after(4);
        n_checks++; if (div_n !== 6'd10) begin n_errors++; $display("FAIL illegal_then_legal: got %0d expected 10", div_n); end
        repeat (4) wrap_after(4);
        mdl_n = 10; mdl_frac = 0; mdl_mode = 0; mdl_k = 0; mdl_last = 10;
    endtask

    task automatic test_frac_dither();
        int sum;
        drive_req(10, 8'h40, 1'b1, 1'b0);
        wrap_after(2);
        n_checks++; if (div_n !== 6'd10) begin n_errors++; $display("FAIL frac_apply: got %0d expected 10", div_n); end
        for (int s = 1; s <= 4; s++) begin
            wrap_after($urandom_range(2, 9));
            n_checks++; if (div_n !== 6'd10) begin n_errors++; $display("FAIL frac_settle_hold: wrap %0d got %0d expected 10", s, div_n); end
        end
        n_checks++; if (busy !== 1'b0) begin n_errors++; $display("FAIL frac_run: busy %b expected 0", busy); end
        mdl_n = 10; mdl_frac = 64; mdl_mode = 1; mdl_k = 0;
        sum = 0;
        for (int k = 0; k < 64; k++) begin
            wrap_after($urandom_range(2, 9));
            mdl_last = dither_n(mdl_k);
            mdl_k++;
            n_checks++; if (div_n !== 6'(mdl_last)) begin n_errors++; $display("FAIL frac_period: period %0d got %0d expected %0d", k, div_n, mdl_last); end
            sum += int'(div_n);
        end
        n_checks++; if (sum != 656) begin n_errors++; $display("FAIL frac_mean: sum %0d expected 656 (10.25 x 64)", sum); end
    endtask

    task automatic test_watchdog();
        drive_req(20, 0, 1'b0, 1'b0);
        repeat (255) tick();
        n_checks++; if (div_n !== 6'(mdl_last) || wdog_to !== 1'b0 || busy !== 1'b1) begin n_errors++; $display("FAIL wdog_early: div_n %0d wdog %b busy %b expected %0d 0 1", div_n, wdog_to, busy, mdl_last); end
        tick();
        n_checks++; if (div_n !== 6'd20 || wdog_to !== 1'b1) begin n_errors++; $display("FAIL wdog_fire: div_n %0d wdog %b expected 20 1", div_n, wdog_to); end
        repeat (4) wrap_after(3);
        n_checks++; if (busy !== 1'b0 || wdog_to !== 1'b1) begin n_errors++; $display("FAIL wdog_sticky: busy %b wdog %b expected 0 1", busy, wdog_to); end
        drive_req(25, 0, 1'b0, 1'b0);
        n_checks++; if (wdog_to !== 1'b0) begin n_errors++; $display("FAIL wdog_clear: got %b expected 0", wdog_to); end
        repeat (255) tick();
        div_wrap = 1'b1;
        tick();
        div_wrap = 1'b0;
        n_checks++; if (div_n !== 6'd25 || wdog_to !== 1'b0) begin n_errors++; $display("FAIL wdog_coincident: div_n %0d wdog %b expected 25 0", div_n, wdog_to); end
        repeat (4) wrap_after(3);
        mdl_n = 25; mdl_frac = 0; mdl_mode = 0; mdl_k = 0; mdl_last = 25;
    endtask

    task automatic test_async_reset();
        drive_req(0, 0, 1'b0, 1'b0);
        drive_req(30, 0, 1'b0, 1'b0);
        wrap_after(3);
        wrap_after(3);
        n_checks++; if (div_n !== 6'd30 || busy !== 1'b1) begin n_errors++; $display("FAIL areset_pre: div_n %0d busy %b expected 30 1", div_n, busy); end
        #2 rstn_s = 1'b0;
        #1;
        n_checks++; if (div_n !== 6'd8 || busy !== 1'b0 || cfg.cfg_ready !== 1'b1) begin n_errors++; $display("FAIL areset_now: div_n %0d busy %b ready %b expected 8 0 1", div_n, busy, cfg.cfg_ready); end
        @(negedge clk);
        rstn_s = 1'b1;
        mdl_n = 8; mdl_frac = 0; mdl_mode = 0; mdl_k = 0; mdl_last = 8;
        repeat (2) wrap_after(5);
        n_checks++; if (div_n !== 6'd8 || busy !== 1'b0) begin n_errors++; $display("FAIL areset_lost: div_n %0d busy %b expected 8 0", div_n, busy); end
    endtask

    task automatic test_back_to_back();
        int tbl_n [4] = '{2, 63, 62, 0};
        int tbl_f [4] = '{0, 0, 255, 7};
        int tbl_m [4] = '{0, 0, 1, 1};
        for (int it = 0; it < 14; it++) begin
            int n;
            int f;
            int runs;
            bit m;
            bit ww;
            bit legal;
            if (it < 4) begin
                n = tbl_n[it]; f = tbl_f[it]; m = tbl_m[it][0];
            end else begin
                n = $urandom_range(0, 63); f = $urandom_range(0, 255); m = 1'($urandom_range(0, 1));
            end
            ww    = 1'($urandom_range(0, 1));
            legal = (n >= 2) && (n <= 63 - int'(m));
            if (ww) begin
                mdl_last = dither_n(mdl_k);
                mdl_k++;
            end
            drive_req(n, f, m, ww);
            n_checks++; if (div_n !== 6'(mdl_last) || cfg_err !== !legal || busy !== legal) begin n_errors++; $display("FAIL req_accept: n %0d m %0d div_n %0d err %b busy %b expected %0d %b %b", n, m, div_n, cfg_err, busy, mdl_last, !legal, legal); end
            if (legal) begin
                if (ww) begin
                    tick();
                    n_checks++; if (div_n !== 6'(mdl_last) || busy !== 1'b1) begin n_errors++; $display("FAIL req_wait_next_wrap: div_n %0d busy %b expected %0d 1", div_n, busy, mdl_last); end
                end
                wrap_after($urandom_range(1, 5));
                n_checks++; if (div_n !== 6'(n)) begin n_errors++; $display("FAIL req_apply: got %0d expected %0d", div_n, n); end
                mdl_n = n; mdl_frac = f; mdl_mode = int'(m); mdl_k = 0; mdl_last = n;
                for (int s = 1; s <= 4; s++) begin
                    wrap_after($urandom_range(1, 5));
                    n_checks++; if (busy !== (s < 4) || div_n !== 6'(n)) begin n_errors++; $display("FAIL req_settle: wrap %0d busy %b div_n %0d expected %b %0d", s, busy, div_n, (s < 4), n); end
                end
            end
            runs = $urandom_range(3, 10);
            for (int j = 0; j < runs; j++) begin
                wrap_after($urandom_range(1, 5));
                mdl_last = dither_n(mdl_k);
                mdl_k++;
                n_checks++; if (div_n !== 6'(mdl_last)) begin n_errors++; $display("FAIL run_dither: n %0d frac %0d k %0d got %0d expected %0d", mdl_n, mdl_frac, mdl_k - 1, div_n, mdl_last); end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation time limit reached, got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_integer_change();
        test_illegal();
        test_frac_dither();
        test_watchdog();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
